// File: rtl/window5x5_pkg.sv
// Shared constants and helpers for the 5x5 window generator.
// DATA_BITS default is common with the downstream conv filter.
package window5x5_pkg;
  localparam int K = 5;
  localparam int DATA_BITS_DEF = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int COL_W_DEF = clog2(IMG_W_DEF);
  localparam int ROW_W_DEF = clog2(IMG_H_DEF);
endpackage

// File: rtl/window5x5_gen_line_buffer_row.sv
// One image-row delay: IMG_W x DATA_BITS memory.
// Synchronous write, combinational read.
module line_buffer_row #(
  parameter int DEPTH     = 28,
  parameter int DATA_BITS = 8,
  parameter int AW        = 5
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o
);
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/window5x5_gen.sv
// Streaming 5x5 sliding-window generator, raster input,
// emits windows only at fully populated positions.
module window5x5_gen
  import window5x5_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] pixel_in,
  output logic                        valid_out,
  output logic signed [DATA_BITS-1:0] p00, p01, p02, p03, p04,
  output logic signed [DATA_BITS-1:0] p10, p11, p12, p13, p14,
  output logic signed [DATA_BITS-1:0] p20, p21, p22, p23, p24,
  output logic signed [DATA_BITS-1:0] p30, p31, p32, p33, p34,
  output logic signed [DATA_BITS-1:0] p40, p41, p42, p43, p44,
  output logic                        frame_done
);
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);

  typedef logic signed [DATA_BITS-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          fd_q, fd_d;
  logic          col_last, row_last;
  pix_t          win_q [K][K];
  logic [DATA_BITS-1:0] lb_rd [K-1];
  logic [DATA_BITS-1:0] lb_wd [K-1];

  // lb0 takes the new pixel; each deeper row takes the one above it
  always_comb begin
    lb_wd[0] = pixel_in;
    for (int i = 1; i < K - 1; i++)
      lb_wd[i] = lb_rd[i-1];
  end

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    line_buffer_row #(
      .DEPTH    (IMG_W),
      .DATA_BITS(DATA_BITS),
      .AW       (CW)
    ) u_lb (
      .clk    (clk),
      .we_i   (valid_in),
      .addr_i (col_q),
      .wdata_i(lb_wd[g]),
      .rdata_o(lb_rd[g])
    );
  end

  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    if (valid_in) begin
      valid_d = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
      fd_d    = col_last && row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win_q[r][c] <= win_q[r][c+1];
      // right column: oldest row on top, live pixel at the bottom
      for (int r = 0; r < K - 1; r++)
        win_q[r][K-1] <= pix_t'(lb_rd[K-2-r]);
      win_q[K-1][K-1] <= pixel_in;
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = fd_q;

  assign p00 = win_q[0][0];
  assign p01 = win_q[0][1];
  assign p02 = win_q[0][2];
  assign p03 = win_q[0][3];
  assign p04 = win_q[0][4];
  assign p10 = win_q[1][0];
  assign p11 = win_q[1][1];
  assign p12 = win_q[1][2];
  assign p13 = win_q[1][3];
  assign p14 = win_q[1][4];
  assign p20 = win_q[2][0];
  assign p21 = win_q[2][1];
  assign p22 = win_q[2][2];
  assign p23 = win_q[2][3];
  assign p24 = win_q[2][4];
  assign p30 = win_q[3][0];
  assign p31 = win_q[3][1];
  assign p32 = win_q[3][2];
  assign p33 = win_q[3][3];
  assign p34 = win_q[3][4];
  assign p40 = win_q[4][0];
  assign p41 = win_q[4][1];
  assign p42 = win_q[4][2];
  assign p43 = win_q[4][3];
  assign p44 = win_q[4][4];
endmodule

// File: tb/tb_window5x5_gen.sv
// Randomised bench for window5x5_gen on an 8x6 frame,
// checked against an image-array model of the window.
module tb_window5x5_gen;
  localparam int W = 8;
  localparam int H = 6;

  logic                    clk;
  logic                    rst;
  logic                    valid_in;
  logic signed [7:0]       pixel_in;
  logic                    valid_out;
  logic                    frame_done;
  logic signed [7:0]       dut_p [5][5];

  window5x5_gen #(.DATA_BITS(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .pixel_in(pixel_in),
    .valid_out(valid_out),
    .p00(dut_p[0][0]), .p01(dut_p[0][1]), .p02(dut_p[0][2]),
    .p03(dut_p[0][3]), .p04(dut_p[0][4]),
    .p10(dut_p[1][0]), .p11(dut_p[1][1]), .p12(dut_p[1][2]),
    .p13(dut_p[1][3]), .p14(dut_p[1][4]),
    .p20(dut_p[2][0]), .p21(dut_p[2][1]), .p22(dut_p[2][2]),
    .p23(dut_p[2][3]), .p24(dut_p[2][4]),
    .p30(dut_p[3][0]), .p31(dut_p[3][1]), .p32(dut_p[3][2]),
    .p33(dut_p[3][3]), .p34(dut_p[3][4]),
    .p40(dut_p[4][0]), .p41(dut_p[4][1]), .p42(dut_p[4][2]),
    .p43(dut_p[4][3]), .p44(dut_p[4][4]),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit ramp     = 0;
  bit stop_cmp = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  int  img [H][W];
  int  exp_win [5][5];
  bit  known;
  bit  exp_valid, exp_fd;
  int  mr, mc, ar, ac;
  int  acc_cnt, win_cnt;
  int  last_pix;

  initial begin : compare
    bit acc, rs;
    int pix;
    forever begin
      @(posedge clk);
      if (stop_cmp) break;
      rs  = rst;
      acc = valid_in && !rst;
      pix = int'(pixel_in);
      if (rs) begin
        mr = 0; mc = 0;
        exp_valid = 0; exp_fd = 0; known = 1;
        acc_cnt = 0; win_cnt = 0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            exp_win[r][c] = 0;
      end else if (acc) begin
        img[mr][mc] = pix;
        last_pix = pix;
        ar = mr; ac = mc;
        acc_cnt++;
        exp_valid = (mr >= 4) && (mc >= 4);
        exp_fd = (mr == H - 1) && (mc == W - 1);
        known = exp_valid;
        if (exp_valid)
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              exp_win[r][c] = img[mr-4+r][mc-4+c];
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end else begin
        exp_valid = 0;
        exp_fd = 0;
      end
      #1;
      chk("valid_out", int'(valid_out), int'(exp_valid));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (known)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            chk($sformatf("p%0d%0d", r, c),
                int'(dut_p[r][c]), exp_win[r][c]);
      if (!rs && acc && valid_out) begin
        win_cnt++;
        chk("p44_last_in", int'(dut_p[4][4]), last_pix);
        if (ramp && ar == 4 && ac == 4) begin
          chk("ramp_first_p00", int'(dut_p[0][0]), 0);
          chk("ramp_first_p04", int'(dut_p[0][4]), 4);
          chk("ramp_first_p40", int'(dut_p[4][0]), 32);
          chk("ramp_first_p44", int'(dut_p[4][4]), 36);
        end
        if (ramp && ar == 5 && ac == 4) begin
          chk("ramp_54_p00", int'(dut_p[0][0]), 8);
          chk("ramp_54_p44", int'(dut_p[4][4]), 44);
        end
      end
      if (!rs && frame_done) begin
        chk("accepts_per_frame", acc_cnt, W * H);
        chk("windows_per_frame", win_cnt, (W - 4) * (H - 4));
        acc_cnt = 0;
        win_cnt = 0;
      end
    end
  end

  task automatic send(input int v);
    @(posedge clk);
    #2;
    valid_in = 1'b1;
    pixel_in = 8'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      valid_in = 1'b0;
      pixel_in = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic ramp_frame(input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r * W + c);
        if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      end
  endtask

  initial begin : drive
    rst = 1'b1;
    valid_in = 1'b0;
    pixel_in = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);
    ramp = 1;
    ramp_frame(0);
    idle(3);
    ramp_frame(3);
    ramp_frame(0);
    ramp_frame(0);
    ramp = 0;
    for (int i = 0; i < W * H; i++)
      send((i % 2) != 0 ? 127 : -128);
    for (int i = 0; i < W * H; i++) begin
      send(int'($urandom_range(255, 0)));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(255, 0)));
    do_reset(3);
    ramp = 1;
    ramp_frame(0);
    ramp = 0;
    idle(4);
    stop_cmp = 1;
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
